// File: rtl/calc_pkg.sv
// Shared constants, types and weight helpers for the slider-driven operand entry.
package calc_pkg;

    localparam int unsigned OPERAND_W         = 14;
    localparam int unsigned DEFAULT_MAX_VALUE = 9999;
    localparam int unsigned MAX_SLIDERS       = 5;

    typedef logic [OPERAND_W-1:0] operand_t;

    typedef enum logic {
        CH_DEBOUNCE,
        CH_REPEAT
    } ch_state_e;

    function automatic int unsigned pow10(input int unsigned i);
        int unsigned p;
        p = 1;
        for (int unsigned k = 0; k < i; k++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam int unsigned WEIGHT_TABLE [MAX_SLIDERS] = '{
        pow10(0), pow10(1), pow10(2), pow10(3), pow10(4)
    };

endpackage

// File: rtl/slider_increment_multi_if.sv
// Slider inputs, operand selection/clear and operand outputs of the entry block.
interface slider_increment_multi_if #(
    parameter int unsigned N_SLIDERS    = 4,
    parameter int unsigned NUM_OPERANDS = 2,
    parameter int unsigned WIDTH        = 14
);
    localparam int unsigned SEL_W = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;

    logic [N_SLIDERS-1:0]               slider;
    logic                               direction;
    logic [SEL_W-1:0]                   write_number_select;
    logic                               clear;
    logic [NUM_OPERANDS-1:0][WIDTH-1:0] number;
    logic                               limit_hit;

    modport master (
        output slider, direction, write_number_select, clear,
        input  number, limit_hit
    );

    modport slave (
        input  slider, direction, write_number_select, clear,
        output number, limit_hit
    );
endinterface

// File: rtl/slider_increment_multi_channel.sv
// One slider: 2-FF synchroniser, debounce and hold-to-repeat step pulse generator.
module slider_channel
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE      = 2,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic slider_raw,
    output logic step_c
);
    localparam int unsigned CNT_MAX = (DEBOUNCE > REPEAT_PERIOD) ? DEBOUNCE : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [1:0]       sync_q;
    logic             s;
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= CH_DEBOUNCE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], slider_raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt counts completed high cycles; in CH_REPEAT it counts cycles since the last pulse
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_c  = 1'b0;
        if (!s) begin
            state_d = CH_DEBOUNCE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                CH_DEBOUNCE: begin
                    if (cnt_q == CNT_W'(DEBOUNCE)) begin
                        step_c  = 1'b1;
                        state_d = CH_REPEAT;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CH_REPEAT: begin
                    if (REPEAT_PERIOD != 0) begin
                        if (cnt_q == CNT_W'(REPEAT_PERIOD)) begin
                            step_c = 1'b1;
                            cnt_d  = CNT_W'(1);
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = CH_DEBOUNCE;
                    cnt_d   = '0;
                end
            endcase
        end
    end
endmodule

// File: rtl/slider_increment_multi.sv
// Operand register file updated by weighted slider steps with saturate or wrap limits.
module slider_increment_multi
    import calc_pkg::*;
#(
    parameter int unsigned N_SLIDERS     = 4,
    parameter int unsigned NUM_OPERANDS  = 2,
    parameter int unsigned WIDTH         = OPERAND_W,
    parameter int unsigned MAX_VALUE     = DEFAULT_MAX_VALUE,
    parameter int unsigned DEBOUNCE      = 2,
    parameter int unsigned REPEAT_PERIOD = 4,
    parameter int unsigned SATURATE      = 1
) (
    input logic                    clk,
    input logic                    rst_ext_n,
    slider_increment_multi_if.slave bus
);
    localparam int unsigned CALC_W = WIDTH + 2;
    localparam int unsigned SEL_W  = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
    localparam logic signed [CALC_W-1:0] MAX_S = CALC_W'(MAX_VALUE);
    localparam logic signed [CALC_W-1:0] MOD_S = CALC_W'(MAX_VALUE + 1);

    logic [N_SLIDERS-1:0]               step_c;
    logic [NUM_OPERANDS-1:0][WIDTH-1:0] regs_q, regs_d;
    logic                               limit_hit_q, hit_d;
    logic [SEL_W-1:0]                   sel_c;
    logic                               sel_valid_c;
    logic                               any_step_c;
    logic                               fold_c;
    logic signed [CALC_W-1:0]           cur_c, delta_c, sum_c, res_c;

    for (genvar i = 0; i < N_SLIDERS; i++) begin : g_ch
        slider_channel #(
            .DEBOUNCE      (DEBOUNCE),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_ext_n),
            .slider_raw (bus.slider[i]),
            .step_c     (step_c[i])
        );
    end

    assign sel_c       = bus.write_number_select;
    assign sel_valid_c = (32'(sel_c) < NUM_OPERANDS);
    assign any_step_c  = |step_c;
    assign cur_c       = $signed({2'b00, regs_q[sel_c]});

    // Coincident pulses merge into a single weighted delta
    always_comb begin
        delta_c = '0;
        for (int i = 0; i < int'(N_SLIDERS); i++) begin
            if (step_c[i]) begin
                delta_c = delta_c + CALC_W'(WEIGHT_TABLE[i]);
            end
        end
    end

    assign sum_c = bus.direction ? (cur_c - delta_c) : (cur_c + delta_c);

    always_comb begin
        res_c  = sum_c;
        fold_c = 1'b0;
        if (sum_c < 0) begin
            fold_c = 1'b1;
            res_c  = (SATURATE != 0) ? '0 : (sum_c + MOD_S);
        end else if (sum_c > MAX_S) begin
            fold_c = 1'b1;
            res_c  = (SATURATE != 0) ? MAX_S : (sum_c - MOD_S);
        end
    end

    // clear beats a coincident step; out-of-range selects drop everything
    always_comb begin
        regs_d = regs_q;
        hit_d  = 1'b0;
        if (sel_valid_c) begin
            if (bus.clear) begin
                regs_d[sel_c] = '0;
            end else if (any_step_c) begin
                regs_d[sel_c] = res_c[WIDTH-1:0];
                hit_d         = fold_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) begin
            regs_q      <= '0;
            limit_hit_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            limit_hit_q <= hit_d;
        end
    end

    assign bus.number    = regs_q;
    assign bus.limit_hit = limit_hit_q;
endmodule

// File: tb/tb_slider_increment_multi.sv
// Directed bench: a saturating and a wrapping instance driven by identical stimulus.
module tb_slider_increment_multi;
    logic       clk = 1'b0;
    logic       rst_ext_n = 1'b0;
    logic [3:0] slider = '0;
    logic       direction = 1'b0;
    logic       sel = 1'b0;
    logic       clear = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int hits_s   = 0;
    int hits_w   = 0;
    int h0_s, h0_w;

    slider_increment_multi_if #(.N_SLIDERS(4), .NUM_OPERANDS(2), .WIDTH(14)) ifs ();
    slider_increment_multi_if #(.N_SLIDERS(4), .NUM_OPERANDS(2), .WIDTH(14)) ifw ();

    assign ifs.slider = slider;
    assign ifs.direction = direction;
    assign ifs.write_number_select = sel;
    assign ifs.clear = clear;
    assign ifw.slider = slider;
    assign ifw.direction = direction;
    assign ifw.write_number_select = sel;
    assign ifw.clear = clear;

    slider_increment_multi #(.SATURATE(1)) dut_s (.clk(clk), .rst_ext_n(rst_ext_n), .bus(ifs));
    slider_increment_multi #(.SATURATE(0)) dut_w (.clk(clk), .rst_ext_n(rst_ext_n), .bus(ifw));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifs.limit_hit) hits_s++;
        if (ifw.limit_hit) hits_w++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One-slider-pattern tap: high for three sampling edges, then long enough low to settle
    task automatic tap(input logic [3:0] mask);
        @(negedge clk);
        slider = mask;
        repeat (3) @(posedge clk);
        @(negedge clk);
        slider = '0;
        repeat (6) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clear(input logic s);
        @(negedge clk);
        sel   = s;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_num0", 32'(ifs.number[0]), 0);
        check("rst_num1", 32'(ifs.number[1]), 0);
        check("rst_hit", 32'(ifs.limit_hit), 0);
        rst_ext_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single tap with exact update edge
        sel = 1'b0;
        h0_s = hits_s;
        slider = 4'b0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        slider = '0;
        @(posedge clk);
        @(negedge clk);
        check("t1_pre_edge4", 32'(ifs.number[0]), 0);
        @(posedge clk);
        @(negedge clk);
        check("t1_edge4", 32'(ifs.number[0]), 1);
        repeat (8) @(negedge clk);
        check("t1_no_repeat", 32'(ifs.number[0]), 1);
        check("t1_other", 32'(ifs.number[1]), 0);
        check("t1_wrap", 32'(ifw.number[0]), 1);
        check("t1_no_hit", 32'(hits_s - h0_s), 0);

        // 2: hold slider[2] for 14 sampling edges on operand 1
        sel = 1'b1;
        slider = 4'b0100;
        for (int e = 0; e < 18; e++) begin
            int exp_v;
            @(posedge clk);
            @(negedge clk);
            if (e == 13) slider = '0;
            exp_v = (e < 4) ? 0 : (e < 8) ? 100 : (e < 12) ? 200 : 300;
            check($sformatf("t2_hold_e%0d", e), 32'(ifs.number[1]), 32'(exp_v));
        end
        check("t2_op0", 32'(ifs.number[0]), 1);

        // clear, then 3: simultaneous rise merges into one update
        do_clear(1'b0);
        @(negedge clk);
        check("clear_op0", 32'(ifs.number[0]), 0);
        check("clear_keeps_op1", 32'(ifs.number[1]), 300);
        tap(4'b0011);
        check("t3_combined", 32'(ifs.number[0]), 11);
        check("t3_combined_w", 32'(ifw.number[0]), 11);

        // 4: build 9995, then overflow and underflow in both modes
        do_clear(1'b0);
        h0_s = hits_s;
        h0_w = hits_w;
        for (int k = 0; k < 9; k++) tap(4'b1111);
        check("t4_9999", 32'(ifs.number[0]), 9999);
        check("t4_no_hit", 32'(hits_s - h0_s), 0);
        direction = 1'b1;
        for (int k = 0; k < 4; k++) tap(4'b0001);
        check("t4_9995_s", 32'(ifs.number[0]), 9995);
        check("t4_9995_w", 32'(ifw.number[0]), 9995);
        direction = 1'b0;
        h0_s = hits_s;
        h0_w = hits_w;
        tap(4'b0010);
        check("t4_sat_hi", 32'(ifs.number[0]), 9999);
        check("t4_wrap_hi", 32'(ifw.number[0]), 5);
        check("t4_hit_hi_s", 32'(hits_s - h0_s), 1);
        check("t4_hit_hi_w", 32'(hits_w - h0_w), 1);
        do_clear(1'b0);
        direction = 1'b1;
        h0_s = hits_s;
        h0_w = hits_w;
        tap(4'b1000);
        check("t4_sat_lo", 32'(ifs.number[0]), 0);
        check("t4_wrap_lo", 32'(ifw.number[0]), 9000);
        check("t4_hit_lo_s", 32'(hits_s - h0_s), 1);
        check("t4_hit_lo_w", 32'(hits_w - h0_w), 1);
        direction = 1'b0;

        // 5: glitch ignored
        @(negedge clk);
        slider = 4'b1000;
        @(negedge clk);
        slider = '0;
        repeat (8) @(negedge clk);
        check("t5_glitch_s", 32'(ifs.number[0]), 0);
        check("t5_glitch_w", 32'(ifw.number[0]), 9000);

        // 5: reset mid-hold, then fresh debounce
        slider = 4'b0001;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t5_held_step", 32'(ifs.number[0]), 1);
        check("t5_held_step_w", 32'(ifw.number[0]), 9001);
        rst_ext_n = 1'b0;
        #1;
        check("t5_rst_num0", 32'(ifs.number[0]), 0);
        check("t5_rst_num1", 32'(ifs.number[1]), 0);
        check("t5_rst_num0_w", 32'(ifw.number[0]), 0);
        check("t5_rst_hit", 32'(ifs.limit_hit), 0);
        @(negedge clk);
        rst_ext_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t5_redebounce_pre", 32'(ifs.number[0]), 0);
        @(posedge clk);
        @(negedge clk);
        check("t5_redebounce", 32'(ifs.number[0]), 1);
        slider = '0;
        repeat (6) @(negedge clk);

        // 6: redirect repeats by changing the select during a hold
        do_clear(1'b0);
        do_clear(1'b1);
        sel = 1'b0;
        slider = 4'b0001;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 5) sel = 1'b1;
            if (e == 12) slider = '0;
        end
        check("t6_op0", 32'(ifs.number[0]), 1);
        check("t6_op1", 32'(ifs.number[1]), 2);

        // 6: clear coincident with a step on the same operand
        sel = 1'b0;
        slider = 4'b0010;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            clear = (e == 3);
            if (e == 4) slider = '0;
        end
        check("t6_clear_wins", 32'(ifs.number[0]), 0);
        check("t6_clear_wins_w", 32'(ifw.number[0]), 0);
        check("t6_clear_other", 32'(ifs.number[1]), 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
